// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// One radix-2 step per cycle; sign correction and commit happen in a final FIX cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_HOLD = 1'b0
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] dividend_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             accept;
  logic             last_step;
  logic             is_signed;
  logic             commit;
  logic             commit_hilo;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept    = (state == IDLE) && start && !cancel;
  assign last_step = (count == CW'(WIDTH - 1));
  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  assign stall_req = accept | busy;

  // Multiply keeps the running partial product in upper and the multiplier in lower;
  // divide keeps the partial remainder in upper and shifts quotient bits into lower.
  assign mul_addend = lower[0] ? operand : '0;
  assign mul_sum    = {1'b0, upper} + {1'b0, mul_addend};
  assign div_shift  = {upper, lower[WIDTH-1]};
  assign div_ge     = (div_shift >= {1'b0, operand});
  assign div_diff   = div_shift[WIDTH-1:0] - operand;

  assign commit      = (state == FIX) && !cancel;
  assign commit_hilo = commit && !(div_zero && ZERO_HOLD);

  always_ff @(posedge clka) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN: begin
        if (cancel)         state_next = IDLE;
        else if (last_step) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction of the magnitude result; the zero-divisor policy bypasses it.
  always_comb begin
    prod     = {upper, lower};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = dividend_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -upper : upper;
        res_lo = neg_q ? -lower : lower;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      count        <= '0;
      upper        <= '0;
      lower        <= '0;
      operand      <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= commit;
      if (accept) begin
        count        <= '0;
        upper        <= '0;
        lower        <= op[1] ? mag_a : mag_b;
        operand      <= op[1] ? mag_b : mag_a;
        dividend_raw <= src_a;
        is_div       <= op[1];
        neg_q        <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        neg_r        <= is_signed & src_a[WIDTH-1];
        div_zero     <= op[1] & (src_b == '0);
      end else if (state == RUN) begin
        count <= count + CW'(1);
        if (is_div) begin
          upper <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          lower <= {lower[WIDTH-2:0], div_ge};
        end else begin
          upper <= mul_sum[WIDTH:1];
          lower <= {mul_sum[0], lower[WIDTH-1:1]};
        end
      end
    end
  end

  // MTHI/MTLO writes win over a same-cycle commit, register by register.
  always_ff @(posedge clka) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we)            hi <= wdata;
      else if (commit_hilo) hi <= res_hi;
      if (lo_we)            lo <= wdata;
      else if (commit_hilo) lo <= res_lo;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: fixed vectors, corner sequences and random ops
// against an arithmetic reference model, on one instance per divide-by-zero policy.
module tb_hilo_muldiv_unit;

  logic        clka;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic        busy0, done0, stall0, busy1, done1, stall1;

  int errors = 0;
  int checks = 0;
  logic [31:0] mh0, ml0, mh1, ml1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  hilo_muldiv_unit #(.WIDTH(32), .ZERO_HOLD(1'b0)) dut0 (
    .clka(clka), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi0), .lo(lo0), .busy(busy0), .done(done0), .stall_req(stall0)
  );

  hilo_muldiv_unit #(.WIDTH(32), .ZERO_HOLD(1'b1)) dut1 (
    .clka(clka), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi1), .lo(lo1), .busy(busy1), .done(done1), .stall_req(stall1)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and the
  // remainder takes the dividend's sign, matching MIPS DIV.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ph,
                                        input logic [31:0] pl, input bit zh);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mop == 2'd0) r = 64'(sa * sb);
    else if (mop == 2'd1) r = {32'b0, a} * {32'b0, b};
    else if (b == 32'd0) r = zh ? {ph, pl} : {a, 32'hFFFF_FFFF};
    else if (mop == 2'd2) begin
      q = sa / sb;
      m = sa % sb;
      r = {m[31:0], q[31:0]};
    end else r = {a % b, a / b};
    return r;
  endfunction

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
  endtask

  // Called in cycle 1 of an operation; returns the cycle index at which done rose.
  task automatic waitDone(output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = 0;
    while (!done0 && cyc < 60) begin
      if (busy0) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh0, input logic [31:0] el0);
    logic [63:0] r1;
    int cyc, bc;
    r1 = model(o, a, b, mh1, ml1, 1'b1);
    applyStimulus(o, a, b);
    #1;
    checkOutput({name, " stall_req"}, 32'(stall0), 32'd1);
    tick();
    start = 1'b0;
    waitDone(cyc, bc);
    checkOutput({name, " latency"}, 32'(cyc), 32'd34);
    checkOutput({name, " busy cycles"}, 32'(bc), 32'd33);
    checkOutput({name, " busy at done"}, 32'(busy0), 32'd0);
    checkOutput({name, " done1"}, 32'(done1), 32'd1);
    checkOutput({name, " hi0"}, hi0, eh0);
    checkOutput({name, " lo0"}, lo0, el0);
    checkOutput({name, " hi1"}, hi1, r1[63:32]);
    checkOutput({name, " lo1"}, lo1, r1[31:0]);
    mh0 = eh0; ml0 = el0;
    mh1 = r1[63:32]; ml1 = r1[31:0];
  endtask

  initial begin
    logic [63:0] r0;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int cyc, bc;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'd1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
    vecs[8] = '{2'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    mh0 = '0; ml0 = '0; mh1 = '0; ml1 = '0;
    checkOutput("reset hi", hi0, 32'd0);
    checkOutput("reset lo", lo0, 32'd0);
    checkOutput("reset busy", 32'(busy0), 32'd0);
    checkOutput("reset done", 32'(done0), 32'd0);
    checkOutput("reset stall_req", 32'(stall0), 32'd0);

    start = 1'b1; cancel = 1'b1;
    #1;
    checkOutput("cancel masks stall_req", 32'(stall0), 32'd0);
    start = 1'b0; cancel = 1'b0;

    for (int i = 0; i < 9; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // Preload HI/LO, then divide by zero: policy 0 overwrites, policy 1 keeps.
    wdata = 32'h11; hi_we = 1'b1;
    tick();
    hi_we = 1'b0; wdata = 32'h22; lo_we = 1'b1;
    checkOutput("mthi hi0", hi0, 32'h11);
    checkOutput("mthi hi1", hi1, 32'h11);
    tick();
    lo_we = 1'b0;
    checkOutput("mtlo lo1", lo1, 32'h22);
    mh0 = 32'h11; ml0 = 32'h22; mh1 = 32'h11; ml1 = 32'h22;
    runOp("divu zero", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    checkOutput("zero hold hi1", hi1, 32'h11);
    checkOutput("zero hold lo1", lo1, 32'h22);

    // Cancel in cycle 10, restart in cycle 11.
    applyStimulus(2'd1, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checkOutput("cancel busy", 32'(busy0), 32'd0);
    checkOutput("cancel done", 32'(done0), 32'd0);
    checkOutput("cancel hi", hi0, mh0);
    checkOutput("cancel lo", lo0, ml0);
    runOp("after cancel", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12);

    // Reset in the middle of RUN.
    applyStimulus(2'd0, 32'h1234_5678, 32'hFEDC_BA98);
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrun rst hi", hi0, 32'd0);
    checkOutput("midrun rst lo", lo0, 32'd0);
    checkOutput("midrun rst busy", 32'(busy0), 32'd0);
    checkOutput("midrun rst done", 32'(done0), 32'd0);
    checkOutput("midrun rst hi1", hi1, 32'd0);
    mh0 = '0; ml0 = '0; mh1 = '0; ml1 = '0;
    repeat (40) tick();
    checkOutput("no done after rst", 32'(done0), 32'd0);

    // MTLO in the FIX cycle overrides only LO.
    applyStimulus(2'd1, 32'd2, 32'd3);
    tick();
    start = 1'b0;
    repeat (32) tick();
    checkOutput("fix busy", 32'(busy0), 32'd1);
    lo_we = 1'b1; wdata = 32'hABCD;
    tick();
    lo_we = 1'b0;
    checkOutput("fix mtlo done", 32'(done0), 32'd1);
    checkOutput("fix mtlo lo", lo0, 32'hABCD);
    checkOutput("fix mtlo hi", hi0, 32'd0);
    checkOutput("fix mtlo lo1", lo1, 32'hABCD);
    mh0 = '0; ml0 = 32'hABCD; mh1 = '0; ml1 = 32'hABCD;

    // MTHI together with start: visible next cycle, then the product overwrites it.
    applyStimulus(2'd1, 32'd2, 32'd3);
    hi_we = 1'b1; wdata = 32'h5555;
    tick();
    start = 1'b0; hi_we = 1'b0;
    checkOutput("mthi+start hi", hi0, 32'h5555);
    checkOutput("mthi+start busy", 32'(busy0), 32'd1);
    waitDone(cyc, bc);
    checkOutput("mthi+start latency", 32'(cyc), 32'd34);
    checkOutput("mthi+start final hi", hi0, 32'd0);
    checkOutput("mthi+start final lo", lo0, 32'd6);
    mh0 = '0; ml0 = 32'd6; mh1 = '0; ml1 = 32'd6;

    // Random operations, including zero and extreme divisors.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(0, 15);
        2:       rb = 32'd0;
        default: rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      endcase
      r0 = model(rop, ra, rb, mh0, ml0, 1'b0);
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, r0[63:32], r0[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core. It executes MULT/MULTU/DIV/DIVU iteratively over WIDTH cycles, services MTHI/MTLO writes, and exposes HI/LO to the DataMove (MFHI/MFLO) path. It sits beside the execute-stage ALU in the datapath and raises a stall request so the pipeline freezes while an operation is in flight.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- ZERO_HOLD, 0, divide-by-zero policy:
  - 0: LO = all-ones, HI = dividend.
  - 1: HI/LO are left unchanged.

Ports:
- clka  in  1  clock; one clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  multiplicand or dividend (rs).
- src_b  in  WIDTH  multiplier or divisor (rt).
- cancel  in  1  abort any in-flight operation (flush or exception).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- hi  out  WIDTH  HI register (registered).
- lo  out  WIDTH  LO register (registered).
- busy  out  1  registered; high in RUN and FIX.
- done  out  1  registered one-cycle pulse; HI/LO were just committed.
- stall_req  out  1  combinational: (IDLE & start & ~cancel) | busy.

## Operation

- States:
  - IDLE: start & ~cancel captures op, operand magnitudes, and result signs; clears the iteration counter; moves to RUN.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). After WIDTH steps, moves to FIX.
  - FIX: applies sign correction, commits HI/LO, pulses done, returns to IDLE.
- Signed ops (MULT, DIV) negate negative operands at capture. Unsigned ops use operands as-is.
- Multiply: the 2·WIDTH-bit product sets HI = upper WIDTH bits, LO = lower WIDTH bits. The product is negated in FIX if the operand signs differ (signed only).
- Divide:
  - LO = quotient, truncated toward zero; HI = remainder, taking the sign of the dividend.
  - Most-negative / −1 (signed): LO = most-negative, HI = 0. No trap.
  - Divisor zero: detected at capture. The full latency still elapses, then the ZERO_HOLD policy applies in FIX. done still pulses.
- start while busy: ignored. Stall is the caller's responsibility.
- hi_we/lo_we: write wdata to HI/LO in any state.
  - In IDLE with start in the same cycle: the write applies and the operation proceeds.
  - In FIX: the MTHI/MTLO write overrides the commit for that register only.
  - hi_we and lo_we together: both registers take wdata.
- cancel:
  - In RUN or FIX: return to IDLE next edge, no commit, done stays 0. HI/LO writes via hi_we/lo_we in that cycle still apply.
  - In IDLE: suppresses start.
- rst (any state, including mid-operation): next edge gives state IDLE, counter 0, hi = lo = 0, busy = 0, done = 0.

## Timing

- Cycle 0: start sampled in IDLE; stall_req = 1 combinationally.
- Cycles 1..WIDTH: RUN, busy = 1.
- Cycle WIDTH+1: FIX, busy = 1.
- Cycle WIDTH+2: done = 1, busy = 0, hi/lo hold the new result; stall_req = 0 unless start is asserted again.
- Total latency is WIDTH+2 cycles from the start edge (34 for WIDTH = 32). Latency is independent of operand values.
- A new start is accepted in the done cycle, giving back-to-back throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO latency: 1 cycle (write edge to visible on hi/lo).
- Reset values: hi = 0, lo = 0, busy = 0, done = 0. stall_req = 0 while start is low.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH = 32) → at cycle 34: done = 1, HI = 0xFFFFFFFE, LO = 0x00000001; busy high for cycles 1–33 only.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0:
  - ZERO_HOLD = 0 → LO = 0xFFFFFFFF, HI = 5, done at cycle 34.
  - ZERO_HOLD = 1 → HI/LO keep the prior values (preload via MTHI = 0x11, MTLO = 0x22), done still at cycle 34.
- Start MULTU 3 × 4, assert cancel at cycle 10 → busy = 0 at cycle 11, no done, HI/LO unchanged. A new start at cycle 11 completes normally at cycle 45. Assert rst mid-RUN → next cycle hi = lo = 0, busy = 0.
- MTLO 0xABCD asserted in the FIX cycle of MULTU 2 × 3 → at done, LO = 0xABCD and HI = 0. MTHI issued with start in the same IDLE cycle → HI = wdata next cycle, and the final product still overwrites HI at commit.
